// File: rtl/demux1x4_buf_pkg.sv
// Shared lane constants, lane-buffer state encoding and a saturating counter helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package demux1x4_buf_pkg;

    localparam int LANES  = 4;
    localparam int SEL_W  = 2;
    localparam int STAT_W = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } lane_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/demux1x4_buf_lane_fifo2.sv
// Two-entry lane buffer: head register plus one tail slot, tracked by an EMPTY/ONE/FULL FSM.
// Latency: a push is visible on head the cycle after it is accepted.
// Backpressure: full blocks further pushes; the head holds its last value once emptied.
module lane_fifo2
    import demux1x4_buf_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    lane_state_t  state_q, state_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         push_ok, pop_ok;

    // Next occupancy state and data movement; pushes into FULL and pops from EMPTY are ignored.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        push_ok = push && (state_q != FULL);
        pop_ok  = pop && (state_q != EMPTY);
        case (state_q)
            EMPTY: begin
                if (push_ok) begin
                    state_d = ONE;
                    head_d  = push_data;
                end
            end
            ONE: begin
                if (push_ok && pop_ok) begin
                    head_d = push_data;
                end else if (push_ok) begin
                    state_d = FULL;
                    tail_d  = push_data;
                end else if (pop_ok) begin
                    // head keeps the popped word so an idle lane shows its last value
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop_ok) begin
                    state_d = ONE;
                    head_d  = tail_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // State and storage registers; reset discards anything buffered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign full  = (state_q == FULL);
    assign empty = (state_q == EMPTY);
    assign head  = head_q;

endmodule

// File: rtl/demux1x4_buf.sv
// 1:4 demux of one valid/ready stream into four independently drained 2-deep lanes (optional DEMUX_STATS_EN per-lane counters).
// Latency: 1 cycle from accept to the word appearing on its lane.
// Backpressure: in_ready = target lane not full; a stalled word (and the RR pointer) waits, no skip-ahead.
module demux1x4_buf
    import demux1x4_buf_pkg::*;
#(
    parameter int W       = 3,
    parameter int RR_MODE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [W-1:0]            in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [LANES*W-1:0]      out_data,
    output logic [LANES-1:0]        out_valid,
    input  logic [LANES-1:0]        out_ready,
    output logic [SEL_W-1:0]        cur_lane
`ifdef DEMUX_STATS_EN
    ,
    output logic [LANES*STAT_W-1:0] stat_cnt
`endif
);

    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0] tgt;
    logic [LANES-1:0] lane_full, lane_empty;
    logic [LANES-1:0] push, pop;
    logic             accept;

    // Pick the target lane, gate readiness on that lane alone, and steer the push.
    always_comb begin
        tgt      = (RR_MODE != 0) ? rr_ptr_q : in_sel;
        cur_lane = tgt;
        in_ready = !lane_full[tgt];
        accept   = in_valid && in_ready;
        push     = '0;
        if (accept) begin
            push[tgt] = 1'b1;
        end
        pop      = out_valid & out_ready;
        rr_ptr_d = accept ? rr_ptr_q + SEL_W'(1) : rr_ptr_q;
    end

    // Round-robin pointer moves only on an accepted word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign out_valid = ~lane_empty;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        lane_fifo2 #(
            .W(W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .push     (push[k]),
            .pop      (pop[k]),
            .push_data(in_data),
            .full     (lane_full[k]),
            .empty    (lane_empty[k]),
            .head     (out_data[k*W +: W])
        );
    end

`ifdef DEMUX_STATS_EN
    logic [STAT_W-1:0] cnt_q [LANES];

    // Per-lane accepted-word counters, saturating at all-ones.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (rst) begin
                cnt_q[k] <= '0;
            end else if (push[k]) begin
                cnt_q[k] <= sat_inc(cnt_q[k]);
            end
        end
    end

    // Pack the counters onto the flat output bus, lane k at [k*STAT_W +: STAT_W].
    always_comb begin
        stat_cnt = '0;
        for (int k = 0; k < LANES; k++) begin
            stat_cnt[k*STAT_W +: STAT_W] = cnt_q[k];
        end
    end
`endif

endmodule

// File: tb/tb_demux1x4_buf.sv
// Bench for demux1x4_buf: one instance selected by in_sel, one in round-robin mode.
// A per-lane queue scoreboard follows every handshake; directed tables and sequences cover corners.
// Optional counter checks run when DEMUX_STATS_EN is defined.
module tb_demux1x4_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  in_data0, in_data1;
    logic [1:0]  in_sel0, in_sel1;
    logic        in_valid0, in_valid1;
    logic        in_ready0, in_ready1;
    logic [11:0] out_data0, out_data1;
    logic [3:0]  out_valid0, out_valid1;
    logic [3:0]  out_ready0, out_ready1;
    logic [1:0]  cur_lane0, cur_lane1;
`ifdef DEMUX_STATS_EN
    logic [31:0] stat0, stat1;
`endif

    demux1x4_buf #(.W(3), .RR_MODE(0)) u_sel (
        .clk(clk), .rst(rst), .in_data(in_data0), .in_sel(in_sel0), .in_valid(in_valid0),
        .in_ready(in_ready0), .out_data(out_data0), .out_valid(out_valid0),
        .out_ready(out_ready0), .cur_lane(cur_lane0)
`ifdef DEMUX_STATS_EN
        , .stat_cnt(stat0)
`endif
    );

    demux1x4_buf #(.W(3), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .in_data(in_data1), .in_sel(in_sel1), .in_valid(in_valid1),
        .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready1), .cur_lane(cur_lane1)
`ifdef DEMUX_STATS_EN
        , .stat_cnt(stat1)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard: per-lane queues of expected words, a model RR pointer and model counters.
    logic [2:0] q0 [4][$];
    logic [2:0] q1 [4][$];
    logic [1:0] ptr1;
    logic [7:0] cnt0 [4];
    logic       mon_en = 1'b0;
    logic       push0, push1;

    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                q0[k].delete();
                q1[k].delete();
                cnt0[k] = 8'd0;
            end
            ptr1 = 2'd0;
        end else if (mon_en) begin
            for (int k = 0; k < 4; k++) begin
                chk("sel_out_valid", {31'd0, out_valid0[k]}, {31'd0, q0[k].size() > 0});
                if (q0[k].size() > 0) chk("sel_out_data", {29'd0, out_data0[k*3 +: 3]}, {29'd0, q0[k][0]});
                chk("rr_out_valid", {31'd0, out_valid1[k]}, {31'd0, q1[k].size() > 0});
                if (q1[k].size() > 0) chk("rr_out_data", {29'd0, out_data1[k*3 +: 3]}, {29'd0, q1[k][0]});
`ifdef DEMUX_STATS_EN
                chk("stat_cnt", {24'd0, stat0[k*8 +: 8]}, {24'd0, cnt0[k]});
`endif
            end
            chk("sel_in_ready", {31'd0, in_ready0}, {31'd0, q0[in_sel0].size() < 2});
            chk("sel_cur_lane", {30'd0, cur_lane0}, {30'd0, in_sel0});
            chk("rr_in_ready", {31'd0, in_ready1}, {31'd0, q1[ptr1].size() < 2});
            chk("rr_cur_lane", {30'd0, cur_lane1}, {30'd0, ptr1});
            push0 = in_valid0 && (q0[in_sel0].size() < 2);
            push1 = in_valid1 && (q1[ptr1].size() < 2);
            for (int k = 0; k < 4; k++) begin
                if (out_ready0[k] && q0[k].size() > 0) void'(q0[k].pop_front());
                if (out_ready1[k] && q1[k].size() > 0) void'(q1[k].pop_front());
            end
            if (push0) begin
                q0[in_sel0].push_back(in_data0);
                if (cnt0[in_sel0] != 8'hFF) cnt0[in_sel0] = cnt0[in_sel0] + 8'd1;
            end
            if (push1) begin
                q1[ptr1].push_back(in_data1);
                ptr1 = ptr1 + 2'd1;
            end
        end
    end

    typedef struct {
        logic [1:0]  sel;
        logic [2:0]  dat;
        logic [3:0]  exp_vld;
        logic [11:0] exp_out;
    } vec_t;

    vec_t tbl [4];

    initial begin
        tbl[0] = '{sel: 2'd0, dat: 3'b001, exp_vld: 4'b0001, exp_out: 12'h001};
        tbl[1] = '{sel: 2'd1, dat: 3'b010, exp_vld: 4'b0010, exp_out: 12'h011};
        tbl[2] = '{sel: 2'd2, dat: 3'b100, exp_vld: 4'b0100, exp_out: 12'h111};
        tbl[3] = '{sel: 2'd3, dat: 3'b110, exp_vld: 4'b1000, exp_out: 12'hD11};

        rst = 1'b1;
        in_data0 = '0; in_sel0 = '0; in_valid0 = 1'b0; out_ready0 = 4'b1111;
        in_data1 = '0; in_sel1 = '0; in_valid1 = 1'b0; out_ready1 = 4'b1111;
        tick();
        tick();
        rst = 1'b0;
        mon_en = 1'b1;

        // Reset state
        chk("rst_out_valid", {28'd0, out_valid0}, 32'd0);
        chk("rst_out_data", {20'd0, out_data0}, 32'd0);
        chk("rst_rr_lane", {30'd0, cur_lane1}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready0}, 32'd1);

        // T1: one word per lane via in_sel, all lanes draining
        for (int i = 0; i < 4; i++) begin
            in_sel0 = tbl[i].sel;
            in_data0 = tbl[i].dat;
            in_valid0 = 1'b1;
            #1;
            chk("t1_in_ready", {31'd0, in_ready0}, 32'd1);
            tick();
            chk("t1_out_valid", {28'd0, out_valid0}, {28'd0, tbl[i].exp_vld});
            chk("t1_out_data", {20'd0, out_data0}, {20'd0, tbl[i].exp_out});
        end
        in_valid0 = 1'b0;
        tick();
        chk("t1_idle_valid", {28'd0, out_valid0}, 32'd0);
        chk("t1_idle_hold", {20'd0, out_data0}, 32'h0D11);

        // T2: fill lane 2, stall a third word, then drain in order
        out_ready0 = 4'b0000;
        in_sel0 = 2'd2; in_data0 = 3'b101; in_valid0 = 1'b1;
        tick();
        in_data0 = 3'b011;
        tick();
        in_data0 = 3'b111;
        #1;
        chk("t2_full_rdy", {31'd0, in_ready0}, 32'd0);
        in_sel0 = 2'd0;
        #1;
        chk("t2_other_rdy", {31'd0, in_ready0}, 32'd1);
        in_sel0 = 2'd2;
        tick();
        tick();
        chk("t2_stall_vld", {28'd0, out_valid0}, 32'h4);
        chk("t2_head0", {29'd0, out_data0[8:6]}, 32'h5);
        out_ready0 = 4'b0100;
        tick();
        chk("t2_head1", {29'd0, out_data0[8:6]}, 32'h3);
        chk("t2_rdy_after_pop", {31'd0, in_ready0}, 32'd1);
        tick();
        chk("t2_head2", {29'd0, out_data0[8:6]}, 32'h7);
        in_valid0 = 1'b0;
        tick();
        chk("t2_empty", {28'd0, out_valid0}, 32'd0);
        chk("t2_hold", {29'd0, out_data0[8:6]}, 32'h7);

        // T3: lane 1 in ONE, simultaneous push and pop
        out_ready0 = 4'b0000;
        in_sel0 = 2'd1; in_data0 = 3'b010; in_valid0 = 1'b1;
        tick();
        chk("t3_one_head", {29'd0, out_data0[5:3]}, 32'h2);
        in_data0 = 3'b111;
        out_ready0 = 4'b0010;
        tick();
        chk("t3_swap_vld", {28'd0, out_valid0}, 32'h2);
        chk("t3_swap_head", {29'd0, out_data0[5:3]}, 32'h7);
        in_valid0 = 1'b0;
        out_ready0 = 4'b0000;
        #1;
        chk("t3_not_full", {31'd0, in_ready0}, 32'd1);
        tick();
        chk("t3_still_one", {28'd0, out_valid0}, 32'h2);
        out_ready0 = 4'b1111;
        tick();

        // T4: round-robin lanes, wrap and stall on a full lane
        out_ready1 = 4'b0000;
        for (int i = 1; i <= 6; i++) begin
            in_data1 = 3'(i);
            in_valid1 = 1'b1;
            #1;
            chk("t4_cur_lane", {30'd0, cur_lane1}, (i - 1) % 4);
            tick();
        end
        in_valid1 = 1'b0;
        chk("t4_all_vld", {28'd0, out_valid1}, 32'hF);
        chk("t4_heads", {20'd0, out_data1}, 32'h08D1);
        chk("t4_ptr", {30'd0, cur_lane1}, 32'd2);
        in_valid1 = 1'b1;
        in_data1 = 3'd7;
        tick();
        in_data1 = 3'd0;
        tick();
        in_data1 = 3'b101;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_stall_lane", {30'd0, cur_lane1}, 32'd0);
            chk("t4_stall_rdy", {31'd0, in_ready1}, 32'd0);
        end
        out_ready1 = 4'b0001;
        tick();
        chk("t4_unblock_rdy", {31'd0, in_ready1}, 32'd1);
        tick();
        chk("t4_ptr_moved", {30'd0, cur_lane1}, 32'd1);
        chk("t4_lane0_head", {29'd0, out_data1[2:0]}, 32'h5);
        in_valid1 = 1'b0;
        out_ready1 = 4'b1111;
        tick();
        tick();
        tick();

        // T5: reset with lanes 0 and 3 full and a word pending
        out_ready0 = 4'b0000;
        in_valid0 = 1'b1;
        in_sel0 = 2'd0; in_data0 = 3'b001;
        in_data1 = 3'b110; in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        in_data0 = 3'b010;
        tick();
        in_sel0 = 2'd3; in_data0 = 3'b011;
        tick();
        in_data0 = 3'b100;
        tick();
        chk("t5_full_vld", {28'd0, out_valid0}, 32'h9);
        chk("t5_rr_ptr", {30'd0, cur_lane1}, 32'd2);
        in_sel0 = 2'd0; in_data0 = 3'b111;
        #1;
        chk("t5_pre_rdy", {31'd0, in_ready0}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid0 = 1'b0;
        chk("t5_vld", {28'd0, out_valid0}, 32'd0);
        chk("t5_data", {20'd0, out_data0}, 32'd0);
        chk("t5_cur_lane", {30'd0, cur_lane0}, 32'd0);
        chk("t5_in_ready", {31'd0, in_ready0}, 32'd1);
        chk("t5_rr_lane", {30'd0, cur_lane1}, 32'd0);
        chk("t5_rr_vld", {28'd0, out_valid1}, 32'd0);
        out_ready0 = 4'b1111;

`ifdef DEMUX_STATS_EN
        // T6: counters after reset, then saturation of lane 0
        chk("t6_stat_rst", stat0, 32'd0);
        chk("t6_stat_rst_rr", stat1, 32'd0);
        in_sel0 = 2'd0;
        in_valid0 = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_data0 = 3'(i);
            tick();
        end
        in_valid0 = 1'b0;
        tick();
        chk("t6_lane0_sat", {24'd0, stat0[7:0]}, 32'hFF);
        chk("t6_others", {8'd0, stat0[31:8]}, 32'd0);
`endif

        tick();
        tick();
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
